red_target_locator: RTL and testbench



---
 rtl/red_target_locator_pkg.sv | 17 +
 rtl/red_target_locator_seq_divider.sv | 72 +++++++
 rtl/red_target_locator.sv | 142 ++++++++++++++
 tb/tb_red_target_locator.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/red_target_locator_pkg.sv
// Shared types and default thresholds for the red target locator and its divider.
package red_target_locator_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV_X = 2'd1,
    DIV_Y = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CNT_W          = 20;
  localparam int RED_MIN_DEF    = 512;
  localparam int MARGIN_DEF     = 128;
  localparam int MIN_PIXELS_DEF = 64;
  localparam int BOX_HALF_DEF   = 10;

endpackage

// File: rtl/red_target_locator_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the start cycle already
// produces the first bit, so done follows start by SUM_W cycles.
module seq_divider
  import red_target_locator_pkg::*;
#(
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam int IW = $clog2(SUM_W + 1);

  logic [CNT_W-1:0] rem_p0, div_p0, src_rem, src_div, rem_nxt;
  logic [SUM_W-1:0] quo_p0, src_quo, quo_nxt;
  logic [CNT_W:0]   shifted;
  logic [CNT_W+1:0] trial;
  logic [IW-1:0]    iter;

  always_comb begin
    src_rem = start ? '0 : rem_p0;
    src_quo = start ? dividend : quo_p0;
    src_div = start ? divisor : div_p0;
    shifted = {src_rem, src_quo[SUM_W-1]};
    trial   = {1'b0, shifted} - {2'b00, src_div};
    if (trial[CNT_W+1]) begin
      rem_nxt = shifted[CNT_W-1:0];
      quo_nxt = {src_quo[SUM_W-2:0], 1'b0};
    end else begin
      rem_nxt = trial[CNT_W-1:0];
      quo_nxt = {src_quo[SUM_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      iter <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        iter <= IW'(1);
      end else if (busy) begin
        iter <= iter + IW'(1);
        if (iter == IW'(SUM_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // p0: partial remainder / quotient shift register
  always_ff @(posedge clk) begin
    if (start || busy) begin
      rem_p0 <= rem_nxt;
      quo_p0 <= quo_nxt;
      div_p0 <= src_div;
    end
  end

  assign quotient = quo_p0;

endmodule

// File: rtl/red_target_locator.sv
// Accumulates coordinates of strongly red pixels per frame and publishes the
// marker box top-left (centroid minus BOX_HALF) once the frame has been divided out.
module red_target_locator
  import red_target_locator_pkg::*;
#(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int RED_MIN    = RED_MIN_DEF,
  parameter int MARGIN     = MARGIN_DEF,
  parameter int MIN_PIXELS = MIN_PIXELS_DEF,
  parameter int BOX_HALF   = BOX_HALF_DEF,
  parameter int SUM_W      = 32
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic [9:0]  iRed,
  input  logic [9:0]  iGreen,
  input  logic [9:0]  iBlue,
  input  logic [12:0] iXposition,
  input  logic [12:0] iYposition,
  output logic [12:0] oXresult,
  output logic [12:0] oYresult,
  output logic        oFinished,
  output logic [19:0] oPixelCount,
  output logic        oDrop
);

  function automatic logic [12:0] box_pos(input logic [SUM_W-1:0] q);
    if (q < SUM_W'(BOX_HALF)) return '0;
    return 13'(q - SUM_W'(BOX_HALF));
  endfunction

  state_t           state, state_nxt;
  logic             hit, frame_start, frame_end;
  logic [SUM_W-1:0] sum_x, sum_y, sum_x_nxt, sum_y_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SUM_W-1:0] snap_x_p0, snap_y_p0;
  logic [CNT_W-1:0] snap_cnt_p0;
  logic             vld_p0;
  logic [SUM_W-1:0] qx_p1, qy_p1;
  logic             div_start, div_busy, div_done;
  logic [SUM_W-1:0] div_dividend, div_quot;

  assign hit = ({1'b0, iRed} >= 11'(RED_MIN)) &&
               ({1'b0, iRed} > ({1'b0, iGreen} + 11'(MARGIN))) &&
               ({1'b0, iRed} > ({1'b0, iBlue} + 11'(MARGIN)));

  assign frame_start = iDVAL && (iXposition == 13'd0) && (iYposition == 13'd0);
  assign frame_end   = iDVAL && (iXposition == 13'(H_ACTIVE - 1)) &&
                       (iYposition == 13'(V_ACTIVE - 1));

  always_comb begin
    sum_x_nxt = sum_x;
    sum_y_nxt = sum_y;
    cnt_nxt   = cnt;
    if (frame_start) begin
      // (0,0) contributes nothing to the sums, only to the count
      sum_x_nxt = '0;
      sum_y_nxt = '0;
      cnt_nxt   = hit ? CNT_W'(1) : '0;
    end else if (iDVAL && hit) begin
      sum_x_nxt = sum_x + SUM_W'(iXposition);
      sum_y_nxt = sum_y + SUM_W'(iYposition);
      if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    div_start    = 1'b0;
    div_dividend = snap_x_p0;
    case (state)
      ACCUM: if (frame_end) state_nxt = (cnt_nxt >= CNT_W'(MIN_PIXELS)) ? DIV_X : DONE;
      DIV_X: begin
        if (div_done) begin
          // chain the Y division straight off the X result to avoid an idle cycle
          div_start    = 1'b1;
          div_dividend = snap_y_p0;
          state_nxt    = DIV_Y;
        end else if (!div_busy) begin
          div_start = 1'b1;
        end
      end
      DIV_Y:   if (div_done) state_nxt = DONE;
      DONE:    state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= ACCUM;
      sum_x       <= '0;
      sum_y       <= '0;
      cnt         <= '0;
      oXresult    <= '0;
      oYresult    <= '0;
      oFinished   <= 1'b0;
      oPixelCount <= '0;
      oDrop       <= 1'b0;
    end else begin
      state <= state_nxt;
      sum_x <= sum_x_nxt;
      sum_y <= sum_y_nxt;
      cnt   <= cnt_nxt;
      oDrop <= frame_end && (state != ACCUM);
      if (state == DONE) begin
        oPixelCount <= snap_cnt_p0;
        oFinished   <= vld_p0;
        if (vld_p0) begin
          oXresult <= box_pos(qx_p1);
          oYresult <= box_pos(qy_p1);
        end
      end
    end
  end

  // p0: frame-end snapshot, p1: quotients held until DONE
  always_ff @(posedge iCLK) begin
    if (state == ACCUM && frame_end) begin
      snap_x_p0   <= sum_x_nxt;
      snap_y_p0   <= sum_y_nxt;
      snap_cnt_p0 <= cnt_nxt;
      vld_p0      <= (cnt_nxt >= CNT_W'(MIN_PIXELS));
    end
    if (state == DIV_X && div_done) qx_p1 <= div_quot;
    if (state == DIV_Y && div_done) qy_p1 <= div_quot;
  end

  seq_divider #(.SUM_W(SUM_W)) u_div (
    .clk      (iCLK),
    .rst      (iRST),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (snap_cnt_p0),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

endmodule

// File: tb/tb_red_target_locator.sv
// Self-checking bench for red_target_locator: frames are painted into small
// colour arrays, a model predicts each result and a scoreboard checks it on time.
module tb_red_target_locator;

  localparam int H    = 16;
  localparam int V    = 12;
  localparam int MINP = 4;
  localparam int BOXH = 2;
  localparam int SW   = 32;
  localparam int LAT  = 2 * SW + 2;

  logic        clk = 1'b0;
  logic        rst, dval;
  logic [9:0]  red, green, blue;
  logic [12:0] xpos, ypos;
  logic [12:0] xres, yres;
  logic        fin, drop;
  logic [19:0] pcount;

  red_target_locator #(
    .H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP), .BOX_HALF(BOXH), .SUM_W(SW)
  ) dut (
    .iCLK(clk), .iRST(rst), .iDVAL(dval), .iRed(red), .iGreen(green), .iBlue(blue),
    .iXposition(xpos), .iYposition(ypos), .oXresult(xres), .oYresult(yres),
    .oFinished(fin), .oPixelCount(pcount), .oDrop(drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [12:0] x, y;
    logic        fin;
    logic [19:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          fr_r[V][H], fr_g[V][H], fr_b[V][H];
  int          errors = 0, checks = 0;
  logic [12:0] mdl_x = 0, mdl_y = 0;
  logic        mdl_fin = 0;
  logic [19:0] mdl_cnt = 0;

  // advance one cycle and retire any scoreboard entry that is due
  task automatic tick();
    exp_t        e;
    logic [12:0] ex, ey;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      mdl_x = 0; mdl_y = 0; mdl_fin = 0; mdl_cnt = 0;
    end else if (exp_q.size() > 0) begin
      e = exp_q[0];
      if (cyc == e.due - 1) begin
        checks++;
        if ({xres, yres, fin, pcount} !== {mdl_x, mdl_y, mdl_fin, mdl_cnt}) begin
          errors++;
          $display("FAIL early_update: got x=%0d y=%0d fin=%0b cnt=%0d, want unchanged x=%0d y=%0d fin=%0b cnt=%0d",
                   xres, yres, fin, pcount, mdl_x, mdl_y, mdl_fin, mdl_cnt);
        end
      end else if (cyc == e.due) begin
        ex = e.fin ? e.x : mdl_x;
        ey = e.fin ? e.y : mdl_y;
        checks++;
        if (xres !== ex) begin errors++; $display("FAIL xresult: got %0d want %0d", xres, ex); end
        checks++;
        if (yres !== ey) begin errors++; $display("FAIL yresult: got %0d want %0d", yres, ey); end
        checks++;
        if (fin !== e.fin) begin errors++; $display("FAIL finished: got %0b want %0b", fin, e.fin); end
        checks++;
        if (pcount !== e.cnt) begin errors++; $display("FAIL pixelcount: got %0d want %0d", pcount, e.cnt); end
        mdl_x = ex; mdl_y = ey; mdl_fin = e.fin; mdl_cnt = e.cnt;
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      dval = 1'b0;
    end
  endtask

  task automatic clear_frame();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        fr_r[y][x] = 0; fr_g[y][x] = 0; fr_b[y][x] = 0;
      end
  endtask

  task automatic paint(input int x0, input int x1, input int y0, input int y1,
                       input int r, input int g, input int b);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        fr_r[y][x] = r; fr_g[y][x] = g; fr_b[y][x] = b;
      end
  endtask

  // drives the frame with a red dval=0 gap per line; returns right after the last pixel
  task automatic send_frame(input bit last_ok);
    exp_t e;
    int   sx, sy, n, qx, qy;
    for (int y = 0; y < V; y++) begin
      tick();
      dval = 1'b0; xpos = 13'd3; ypos = 13'(y); red = 10'd1023; green = 10'd0; blue = 10'd0;
      for (int x = 0; x < H; x++) begin
        tick();
        dval  = (x == H - 1 && y == V - 1) ? last_ok : 1'b1;
        xpos  = 13'(x); ypos = 13'(y);
        red   = 10'(fr_r[y][x]); green = 10'(fr_g[y][x]); blue = 10'(fr_b[y][x]);
      end
    end
    if (last_ok) begin
      sx = 0; sy = 0; n = 0;
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++)
          if (fr_r[y][x] >= 512 && fr_r[y][x] > fr_g[y][x] + 128 && fr_r[y][x] > fr_b[y][x] + 128) begin
            sx += x; sy += y; n++;
          end
      e.fin = (n >= MINP);
      e.cnt = 20'(n);
      e.due = cyc + 1 + (e.fin ? LAT : 1);
      qx = e.fin ? sx / n : 0;
      qy = e.fin ? sy / n : 0;
      e.x = (qx >= BOXH) ? 13'(qx - BOXH) : 13'd0;
      e.y = (qy >= BOXH) ? 13'(qy - BOXH) : 13'd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dval = 1'b0; red = 0; green = 0; blue = 0; xpos = 0; ypos = 0;
    wait_cycles(3);
    checks++; if (xres !== 13'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", xres); end
    checks++; if (yres !== 13'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", yres); end
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL reset_fin: got %0b want 0", fin); end
    checks++; if (pcount !== 20'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", pcount); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0b want 0", drop); end
    rst = 1'b0;
  endtask

  task automatic test_square();
    clear_frame(); paint(4, 7, 2, 5, 1023, 0, 0);
    send_frame(1'b1); wait_cycles(LAT + 2);
  endtask

  task automatic test_no_result();
    clear_frame(); paint(1, 3, 1, 1, 1023, 0, 0);
    send_frame(1'b1); wait_cycles(3);
  endtask

  task automatic test_clamp();
    clear_frame(); paint(0, 1, 0, 1, 1023, 0, 0);
    send_frame(1'b1); wait_cycles(LAT + 2);
  endtask

  task automatic test_colour();
    clear_frame();
    paint(1, 1, 1, 1, 600, 500, 0);
    paint(2, 2, 1, 1, 700, 500, 0);
    paint(3, 3, 1, 1, 500, 0, 0);
    paint(8, 11, 8, 8, 1023, 0, 0);
    send_frame(1'b1); wait_cycles(LAT + 2);
    checks++;
    if (pcount !== 20'd5) begin errors++; $display("FAIL colour_count: got %0d want 5", pcount); end
  endtask

  task automatic test_reset_in_div();
    clear_frame(); paint(4, 7, 2, 5, 1023, 0, 0);
    send_frame(1'b1);
    wait_cycles(10);
    rst = 1'b1;
    tick();
    checks++; if (xres !== 13'd0) begin errors++; $display("FAIL divrst_x: got %0d want 0", xres); end
    checks++; if (yres !== 13'd0) begin errors++; $display("FAIL divrst_y: got %0d want 0", yres); end
    checks++; if (fin !== 1'b0) begin errors++; $display("FAIL divrst_fin: got %0b want 0", fin); end
    checks++; if (pcount !== 20'd0) begin errors++; $display("FAIL divrst_cnt: got %0d want 0", pcount); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL divrst_drop: got %0b want 0", drop); end
    rst = 1'b0;
    wait_cycles(2);
    send_frame(1'b1); wait_cycles(LAT + 2);
  endtask

  task automatic test_drop();
    clear_frame(); paint(0, 1, 0, 1, 1023, 0, 0);
    send_frame(1'b1);
    for (int i = 1; i <= LAT + 2; i++) begin
      tick();
      dval = 1'b0;
      if (i == 5) begin
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_before: got %0b want 0", drop); end
        dval = 1'b1; xpos = 13'(H - 1); ypos = 13'(V - 1);
      end
      if (i == 6) begin
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %0b want 1", drop); end
      end
      if (i == 7) begin
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL drop_after: got %0b want 0", drop); end
      end
    end
  endtask

  task automatic test_last_invalid();
    clear_frame(); paint(4, 7, 2, 5, 1023, 0, 0);
    send_frame(1'b0); wait_cycles(LAT + 4);
    checks++; if (xres !== mdl_x) begin errors++; $display("FAIL noend_x: got %0d want %0d", xres, mdl_x); end
    checks++; if (yres !== mdl_y) begin errors++; $display("FAIL noend_y: got %0d want %0d", yres, mdl_y); end
    checks++; if (fin !== mdl_fin) begin errors++; $display("FAIL noend_fin: got %0b want %0b", fin, mdl_fin); end
    checks++; if (pcount !== mdl_cnt) begin errors++; $display("FAIL noend_cnt: got %0d want %0d", pcount, mdl_cnt); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_no_result();
    test_clamp();
    test_colour();
    test_reset_in_div();
    test_drop();
    test_last_invalid();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
